mem_responder: RTL and testbench

Target-side memory block that serves the CPU's instruction-fetch/load channel (`m_in_*`) and store channel (`m_out_*`) from an on-chip byte-addressable RAM. It is little-endian and backed by a 32-bit word array with byte enables. It sits directly on the CPU's memory ports in place of an external memory model. It accepts byte, half-word and word accesses at any alignment, splitting word-crossing accesses into two array cycles, and returns exactly one `ready` pulse per request.

---
 rtl/mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: little-endian byte-addressable on-chip RAM serving a CPU read
// channel (m_in_*) and write channel (m_out_*). Accepts byte/half/word accesses
// at any alignment; word-crossing accesses take two array cycles.
// Ports: clk, reset (async, active-high); m_in_sig_read/m_in_addr -> m_in_data,
// m_in_ready; m_out_sig_write/m_out_addr/m_out_data -> m_out_ready; busy;
// err_overrun (sticky, set when a request hits an occupied pending slot).
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m_in_sig_read,
    input  logic [31:0] m_in_addr,
    output logic [31:0] m_in_data,
    output logic        m_in_ready,
    input  logic [1:0]  m_out_sig_write,
    input  logic [31:0] m_out_addr,
    input  logic [31:0] m_out_data,
    output logic        m_out_ready,
    output logic        busy,
    output logic        err_overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = AW + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_WR_LO  = 3'd2;
    localparam logic [2:0] S_WR_HI  = 3'd3;
    localparam logic [2:0] S_RD_LO  = 3'd4;
    localparam logic [2:0] S_RD_HI  = 3'd5;
    localparam logic [2:0] S_RD_OUT = 3'd6;
    localparam logic [2:0] S_RESP   = 3'd7;

    logic [2:0]    r_state;
    logic [3:0]    r_wcnt;
    logic          r_op_wr;
    logic          r_wr_full;
    logic [1:0]    r_wr_size;
    logic [BW-1:0] r_wr_addr;
    logic [31:0]   r_wr_data;
    logic          r_rd_full;
    logic [1:0]    r_rd_size;
    logic [BW-1:0] r_rd_addr;
    logic [31:0]   r_in_data;
    logic          r_overrun;
    logic [31:0]   r_rdata;
    logic [31:0]   r_lo;
    logic [31:0]   r_mem [DEPTH];

    logic [1:0]    w_size;
    logic [BW-1:0] w_addr;
    logic [1:0]    w_off;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_idx_hi;
    logic [3:0]    w_mask4;
    logic [31:0]   w_mask32;
    logic [7:0]    w_be8;
    logic          w_cross;
    logic [4:0]    w_sh;
    logic [63:0]   w_wd64;
    logic [31:0]   w_lo;
    logic [31:0]   w_hi;
    logic [63:0]   w_rd64;
    logic [31:0]   w_rd_res;
    logic          w_clr_wr;
    logic          w_clr_rd;
    logic          w_unused;

    // The request in service is selected by the op latched when leaving IDLE.
    assign w_size   = r_op_wr ? r_wr_size : r_rd_size;
    assign w_addr   = r_op_wr ? r_wr_addr : r_rd_addr;
    assign w_off    = w_addr[1:0];
    assign w_idx    = w_addr[BW-1:2];
    assign w_idx_hi = w_idx + AW'(1);

    always_comb begin
        w_mask4 = 4'b1111;
        case (w_size)
            2'd1:    w_mask4 = 4'b0001;
            2'd2:    w_mask4 = 4'b0011;
            default: w_mask4 = 4'b1111;
        endcase
    end

    assign w_mask32 = {{8{w_mask4[3]}}, {8{w_mask4[2]}},
                       {8{w_mask4[1]}}, {8{w_mask4[0]}}};

    // Lanes 0-3 of w_be8/w_wd64 hit word w, lanes 4-7 hit word w+1.
    assign w_be8   = {4'b0000, w_mask4} << w_off;
    assign w_cross = |w_be8[7:4];
    assign w_sh    = {w_off, 3'b000};
    assign w_wd64  = {32'h0, r_wr_data} << w_sh;

    assign w_lo     = w_cross ? r_lo : r_rdata;
    assign w_hi     = w_cross ? r_rdata : 32'h0;
    assign w_rd64   = {w_hi, w_lo} >> w_sh;
    assign w_rd_res = w_rd64[31:0] & w_mask32;

    assign w_clr_wr = (r_state == S_RESP) && r_op_wr;
    assign w_clr_rd = (r_state == S_RESP) && !r_op_wr;

    assign w_unused = ^{m_in_addr[31:BW], m_out_addr[31:BW]};

    // Array has no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (r_state == S_WR_LO) begin
            for (int i = 0; i < 4; i++)
                if (w_be8[i])
                    r_mem[w_idx][8*i +: 8] <= w_wd64[8*i +: 8];
        end
        if (r_state == S_WR_HI) begin
            for (int i = 0; i < 4; i++)
                if (w_be8[4+i])
                    r_mem[w_idx_hi][8*i +: 8] <= w_wd64[32+8*i +: 8];
        end
        if (r_state == S_RD_LO)
            r_rdata <= r_mem[w_idx];
        if (r_state == S_RD_HI) begin
            r_lo    <= r_rdata;
            r_rdata <= r_mem[w_idx_hi];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wcnt    <= 4'd0;
            r_op_wr   <= 1'b0;
            r_wr_full <= 1'b0;
            r_wr_size <= 2'd0;
            r_wr_addr <= '0;
            r_wr_data <= 32'h0;
            r_rd_full <= 1'b0;
            r_rd_size <= 2'd0;
            r_rd_addr <= '0;
            r_in_data <= 32'h0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_wr_full || r_rd_full) begin
                        r_op_wr <= r_wr_full;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= r_wr_full ? S_WR_LO : S_RD_LO;
                        end else begin
                            r_state <= S_WAIT;
                            r_wcnt  <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == 4'd0)
                        r_state <= r_op_wr ? S_WR_LO : S_RD_LO;
                    else
                        r_wcnt <= r_wcnt - 4'd1;
                end
                S_WR_LO:  r_state <= w_cross ? S_WR_HI : S_RESP;
                S_WR_HI:  r_state <= S_RESP;
                S_RD_LO:  r_state <= w_cross ? S_RD_HI : S_RD_OUT;
                S_RD_HI:  r_state <= S_RD_OUT;
                S_RD_OUT: begin
                    r_in_data <= w_rd_res;
                    r_state   <= S_RESP;
                end
                default:  r_state <= S_IDLE;
            endcase

            // Clear-then-set: a request arriving with the response is kept.
            if (m_out_sig_write != 2'd0) begin
                if (r_wr_full && !w_clr_wr) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_wr_full <= 1'b1;
                    r_wr_size <= m_out_sig_write;
                    r_wr_addr <= m_out_addr[BW-1:0];
                    r_wr_data <= m_out_data;
                end
            end else if (w_clr_wr) begin
                r_wr_full <= 1'b0;
            end

            if (m_in_sig_read != 2'd0) begin
                if (r_rd_full && !w_clr_rd) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_rd_full <= 1'b1;
                    r_rd_size <= m_in_sig_read;
                    r_rd_addr <= m_in_addr[BW-1:0];
                end
            end else if (w_clr_rd) begin
                r_rd_full <= 1'b0;
            end
        end
    end

    assign m_in_data   = r_in_data;
    assign m_in_ready  = w_clr_rd;
    assign m_out_ready = w_clr_wr;
    assign busy        = r_wr_full || r_rd_full || (r_state != S_IDLE);
    assign err_overrun = r_overrun;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: checks three mem_responder instances (default, DEPTH=16,
// WAIT_CYCLES=3) against a byte-level latency model plus directed literals.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst [3];
    logic [1:0]  rs  [3];
    logic [1:0]  ws  [3];
    logic [31:0] ra  [3];
    logic [31:0] wa  [3];
    logic [31:0] wd  [3];
    logic [31:0] idata [3];
    logic        irdy [3];
    logic        ordy [3];
    logic        bsy  [3];
    logic        ovr  [3];

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(rst[0]),
        .m_in_sig_read(rs[0]), .m_in_addr(ra[0]),
        .m_in_data(idata[0]), .m_in_ready(irdy[0]),
        .m_out_sig_write(ws[0]), .m_out_addr(wa[0]),
        .m_out_data(wd[0]), .m_out_ready(ordy[0]),
        .busy(bsy[0]), .err_overrun(ovr[0]));

    mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(rst[1]),
        .m_in_sig_read(rs[1]), .m_in_addr(ra[1]),
        .m_in_data(idata[1]), .m_in_ready(irdy[1]),
        .m_out_sig_write(ws[1]), .m_out_addr(wa[1]),
        .m_out_data(wd[1]), .m_out_ready(ordy[1]),
        .busy(bsy[1]), .err_overrun(ovr[1]));

    mem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u2 (
        .clk(clk), .reset(rst[2]),
        .m_in_sig_read(rs[2]), .m_in_addr(ra[2]),
        .m_in_data(idata[2]), .m_in_ready(irdy[2]),
        .m_out_sig_write(ws[2]), .m_out_addr(wa[2]),
        .m_out_data(wd[2]), .m_out_ready(ordy[2]),
        .busy(bsy[2]), .err_overrun(ovr[2]));

    // ---------------- behavioural model ----------------
    int          DEP [3] = '{1024, 16, 1024};
    int          WT  [3] = '{0, 0, 3};
    byte unsigned mb [3][4096];
    bit          mk  [3][4096];
    bit          m_wf [3], m_rf [3];
    logic [1:0]  m_wsz [3], m_rsz [3];
    logic [31:0] m_wa [3], m_wd [3], m_ra [3];
    bit          job [3], jwr [3];
    int          jrdy [3];
    logic [31:0] jval [3], jmsk [3];
    bit          e_ir [3], e_or [3], e_bsy [3], e_ov [3];
    logic [31:0] e_d [3], e_m [3];

    function automatic int nb(input logic [1:0] sz);
        return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
    endfunction

    function automatic int bidx(input int u, input logic [31:0] a, input int i);
        return int'((a + 32'(i)) % 32'(DEP[u] * 4));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int u = 0; u < 3; u++) begin
            if (rst[u]) begin
                m_wf[u] = 0; m_rf[u] = 0; job[u] = 0;
                e_ir[u] = 0; e_or[u] = 0; e_bsy[u] = 0; e_ov[u] = 0;
                continue;
            end
            e_ir[u] = 0;
            e_or[u] = 0;
            if (job[u] && cyc == jrdy[u]) begin
                if (jwr[u]) begin
                    for (int i = 0; i < nb(m_wsz[u]); i++) begin
                        mb[u][bidx(u, m_wa[u], i)] = m_wd[u][8*i +: 8];
                        mk[u][bidx(u, m_wa[u], i)] = 1;
                    end
                    e_or[u] = 1;
                end else begin
                    e_ir[u] = 1;
                    e_d[u]  = jval[u];
                    e_m[u]  = jmsk[u];
                end
            end else if (job[u] && cyc == jrdy[u] + 1) begin
                job[u] = 0;
                if (jwr[u]) m_wf[u] = 0;
                else        m_rf[u] = 0;
            end
            if (ws[u] != 2'd0) begin
                if (m_wf[u]) e_ov[u] = 1;
                else begin
                    m_wf[u] = 1; m_wsz[u] = ws[u];
                    m_wa[u] = wa[u]; m_wd[u] = wd[u];
                end
            end
            if (rs[u] != 2'd0) begin
                if (m_rf[u]) e_ov[u] = 1;
                else begin
                    m_rf[u] = 1; m_rsz[u] = rs[u]; m_ra[u] = ra[u];
                end
            end
            if (!job[u] && (m_wf[u] || m_rf[u])) begin
                int n, x;
                job[u] = 1;
                jwr[u] = m_wf[u];
                n = jwr[u] ? nb(m_wsz[u]) : nb(m_rsz[u]);
                x = ((jwr[u] ? m_wa[u][1:0] : m_ra[u][1:0]) + n > 4) ? 1 : 0;
                jrdy[u] = cyc + (jwr[u] ? 2 : 3) + WT[u] + x;
                if (!jwr[u]) begin
                    jval[u] = 32'h0;
                    jmsk[u] = 32'hFFFF_FFFF;
                    for (int i = 0; i < n; i++) begin
                        int b;
                        b = bidx(u, m_ra[u], i);
                        if (mk[u][b]) jval[u][8*i +: 8] = mb[u][b];
                        else          jmsk[u][8*i +: 8] = 8'h00;
                    end
                end
            end
            e_bsy[u] = m_wf[u] || m_rf[u];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (rst[u]) begin
                chk($sformatf("u%0d rst outs", u),
                    {idata[u][27:0], irdy[u], ordy[u], bsy[u], ovr[u]},
                    32'h0);
            end else begin
                chk($sformatf("u%0d ctl c%0d", u, cyc),
                    {28'h0, irdy[u], ordy[u], bsy[u], ovr[u]},
                    {28'h0, e_ir[u], e_or[u], e_bsy[u], e_ov[u]});
                if (e_ir[u])
                    chk($sformatf("u%0d data c%0d", u, cyc),
                        idata[u] & e_m[u], e_d[u] & e_m[u]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic go(input int u, input bit is_wr, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d,
                      input int exp_lat, input logic [31:0] exp_d,
                      input logic [31:0] msk, input string nm);
        int lat;
        logic [31:0] got;
        lat = -1;
        got = 32'h0;
        @(negedge clk);
        if (is_wr) begin
            ws[u] = sz; wa[u] = a; wd[u] = d;
        end else begin
            rs[u] = sz; ra[u] = a;
        end
        @(posedge clk);
        #1;
        ws[u] = 2'd0;
        rs[u] = 2'd0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (is_wr ? ordy[u] : irdy[u]) begin
                lat = k;
                got = idata[u];
                break;
            end
        end
        chk({nm, " lat"}, lat, exp_lat);
        if (!is_wr)
            chk({nm, " data"}, got & msk, exp_d & msk);
    endtask

    initial begin
        int wl, rl, rc;
        logic [31:0] rd;
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; rs[u] = 2'd0; ws[u] = 2'd0;
            ra[u] = 32'h0; wa[u] = 32'h0; wd[u] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        chk("reset state", {idata[0][27:0], irdy[0], ordy[0], bsy[0], ovr[0]},
            32'h0);

        go(0, 1, 2'd3, 32'h10, 32'hDEADBEEF, 2, 0, 0, "wr w 10");
        go(0, 0, 2'd3, 32'h10, 0, 3, 32'hDEADBEEF, 32'hFFFFFFFF, "rd w 10");
        go(0, 1, 2'd1, 32'h11, 32'h000000AA, 2, 0, 0, "wr b 11");
        go(0, 0, 2'd3, 32'h10, 0, 3, 32'hDEADAAEF, 32'hFFFFFFFF, "rd w 10b");
        go(0, 0, 2'd2, 32'h12, 0, 3, 32'h0000DEAD, 32'hFFFFFFFF, "rd h 12");
        go(0, 1, 2'd3, 32'h0E, 32'h11223344, 3, 0, 0, "wr w 0e");
        go(0, 0, 2'd3, 32'h0C, 0, 3, 32'h33440000, 32'hFFFF0000, "rd w 0c");
        go(0, 0, 2'd3, 32'h10, 0, 3, 32'hDEAD1122, 32'hFFFFFFFF, "rd w 10c");
        go(0, 0, 2'd3, 32'h0E, 0, 4, 32'h11223344, 32'hFFFFFFFF, "rd w 0e");
        go(0, 0, 2'd2, 32'h0F, 0, 4, 32'h00002233, 32'hFFFFFFFF, "rd h 0f");
        go(0, 0, 2'd1, 32'h13, 0, 3, 32'h000000DE, 32'hFFFFFFFF, "rd b 13");

        // simultaneous read/write, then a read that must be dropped
        @(negedge clk);
        rs[0] = 2'd3; ra[0] = 32'h10;
        ws[0] = 2'd3; wa[0] = 32'h20; wd[0] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        rs[0] = 2'd0; ws[0] = 2'd0;
        @(negedge clk);
        rs[0] = 2'd1; ra[0] = 32'h0;
        @(posedge clk);
        #1;
        rs[0] = 2'd0;
        chk("overrun set", {31'h0, ovr[0]}, 32'h1);
        wl = -1; rl = -1; rc = 0; rd = 32'h0;
        for (int k = 2; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (ordy[0] && wl < 0) wl = k;
            if (irdy[0]) begin
                rc++;
                if (rl < 0) begin
                    rl = k;
                    rd = idata[0];
                end
            end
        end
        chk("sim wr lat", wl, 2);
        chk("sim rd lat", rl, 6);
        chk("sim rd count", rc, 1);
        chk("sim rd data", rd, 32'hDEAD1122);
        chk("overrun sticky", {31'h0, ovr[0]}, 32'h1);
        go(0, 0, 2'd3, 32'h20, 0, 3, 32'hCAFEF00D, 32'hFFFFFFFF, "rd w 20");

        // DEPTH=16 wrap
        go(1, 1, 2'd2, 32'h3F, 32'h0000BEEF, 3, 0, 0, "u1 wr h 3f");
        go(1, 0, 2'd1, 32'h3F, 0, 3, 32'h000000EF, 32'hFFFFFFFF, "u1 rd b 3f");
        go(1, 0, 2'd1, 32'h00, 0, 3, 32'h000000BE, 32'hFFFFFFFF, "u1 rd b 00");
        go(1, 0, 2'd1, 32'h40, 0, 3, 32'h000000BE, 32'hFFFFFFFF, "u1 rd b 40");
        go(1, 0, 2'd2, 32'h3F, 0, 4, 32'h0000BEEF, 32'hFFFFFFFF, "u1 rd h 3f");

        // WAIT_CYCLES=3 and reset during WAIT
        go(2, 1, 2'd3, 32'h08, 32'h12345678, 5, 0, 0, "u2 wr w 08");
        go(2, 0, 2'd3, 32'h08, 0, 6, 32'h12345678, 32'hFFFFFFFF, "u2 rd w 08");
        @(negedge clk);
        rs[2] = 2'd3; ra[2] = 32'h08;
        @(posedge clk);
        #1;
        rs[2] = 2'd0;
        @(posedge clk);
        #1;
        rst[2] = 1'b1;
        #1;
        chk("u2 rst busy", {31'h0, bsy[2]}, 32'h0);
        chk("u2 rst data", idata[2], 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst[2] = 1'b0;
        rc = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (irdy[2] || ordy[2]) rc++;
        end
        chk("u2 no ready after rst", rc, 0);
        go(2, 0, 2'd3, 32'h08, 0, 6, 32'h12345678, 32'hFFFFFFFF, "u2 rd kept");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
